// File: rtl/pipeline_chip2fetch_if.sv
// +--------------------------------------------------------------------------+
// | pipeline_chip2fetch_if : chip-side and fetch-side signals of the inbound |
// | instruction buffer.                                       Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pipeline_chip2fetch_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] instruction_in;
  logic [WIDTH-3:0] progcounter_in;
  logic             chip_valid;
  logic             chip_ready;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] instruction_out;
  logic [WIDTH-3:0] progcounter_out;
  logic             fetch_valid;
  logic [CW-1:0]    fifo_count;

  modport master (
    output instruction_in, progcounter_in, chip_valid, stall, flush,
    input  chip_ready, instruction_out, progcounter_out, fetch_valid, fifo_count
  );

  modport slave (
    input  instruction_in, progcounter_in, chip_valid, stall, flush,
    output chip_ready, instruction_out, progcounter_out, fetch_valid, fifo_count
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_chip2fetch.sv
// +--------------------------------------------------------------------------+
// | pipeline_chip2fetch : show-ahead FIFO handing chip instruction words and |
// | PCs to the fetch stage, with synchronous flush.           Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_chip2fetch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_chip2fetch_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-3:0] pc_mem_q    [DEPTH];

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_nonempty;

  // Ready looks only at the registered count, so a pop cannot free a slot
  // for a push in the same cycle.
  assign w_nonempty = (count_q != '0);
  assign w_ready    = !rst && !bus.flush && (count_q != c_full);
  assign w_push     = bus.chip_valid && w_ready;
  assign w_pop      = w_nonempty && !bus.stall && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      instr_mem_q[wr_ptr_q] <= bus.instruction_in;
      pc_mem_q[wr_ptr_q]    <= bus.progcounter_in;
    end
  end

  assign bus.chip_ready      = w_ready;
  assign bus.fetch_valid     = w_nonempty;
  assign bus.fifo_count      = count_q;
  assign bus.instruction_out = w_nonempty ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.progcounter_out = w_nonempty ? pc_mem_q[rd_ptr_q]    : '0;
endmodule

`default_nettype wire
